// File: rtl/kinematics_solver.sv
// kinematics_solver: mecanum-wheel inverse kinematics in sign-magnitude Q format.
// Wi = (1/r)(vx +/- vy +/- k1*wz), evaluated through one shared multiplier.
// Ports:
//   KINEMATICS_SOLVER_CLOCK_50 / RESET_InLow : clock, async active-low reset
//   KINEMATICS_SOLVER_START_InHigh           : solve request, sampled in IDLE
//   KINEMATICS_SOLVER_TARGET{VX,VY,WZ}_InBus : targets, latched on accept
//   KINEMATICS_SOLVER_W1..W4_OutBus          : wheel speeds, committed together
//   KINEMATICS_SOLVER_BUSY/DONE_OutHigh      : not-IDLE flag, one-cycle done
//   KINEMATICS_SOLVER_OVERFLOW_OutBus        : per-wheel saturation flags
// Optional: define KINEMATICS_SOLVER_SATURATION_EN to clamp instead of wrap.
module kinematics_solver #(
    parameter int                 N_WIDTH    = 32,
    parameter int                 Q_WIDTH    = 15,
    parameter logic [N_WIDTH-1:0] K1_COEF    = 32'h0000151E,
    parameter logic [N_WIDTH-1:0] INV_R_COEF = 32'h000DCB09
) (
    input  logic               KINEMATICS_SOLVER_CLOCK_50,
    input  logic               KINEMATICS_SOLVER_RESET_InLow,
    input  logic               KINEMATICS_SOLVER_START_InHigh,
    input  logic [N_WIDTH-1:0] KINEMATICS_SOLVER_TARGETVX_InBus,
    input  logic [N_WIDTH-1:0] KINEMATICS_SOLVER_TARGETVY_InBus,
    input  logic [N_WIDTH-1:0] KINEMATICS_SOLVER_TARGETWZ_InBus,
    output logic [N_WIDTH-1:0] KINEMATICS_SOLVER_W1_OutBus,
    output logic [N_WIDTH-1:0] KINEMATICS_SOLVER_W2_OutBus,
    output logic [N_WIDTH-1:0] KINEMATICS_SOLVER_W3_OutBus,
    output logic [N_WIDTH-1:0] KINEMATICS_SOLVER_W4_OutBus,
    output logic               KINEMATICS_SOLVER_BUSY_OutHigh,
    output logic               KINEMATICS_SOLVER_DONE_OutHigh,
    output logic [3:0]         KINEMATICS_SOLVER_OVERFLOW_OutBus
);
    localparam int MW = N_WIDTH - 1;
`ifdef KINEMATICS_SOLVER_SATURATION_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_K,
        S_SUM,
        S_MUL_W,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q;
    logic [N_WIDTH-1:0] vx_q, vy_q, wz_q, kw_q;
    logic               kw_ov_q;
    logic [N_WIDTH-1:0] sum_q [4];
    logic [3:0]         sov_q;
    logic [N_WIDTH-1:0] res_q [3];
    logic [2:0]         rov_q;
    logic [N_WIDTH-1:0] mul_a, mul_b;
    logic [N_WIDTH:0]   mul_r;
    logic [N_WIDTH:0]   t_mv, t_pv, s1, s2, s3, s4;

    function automatic logic [N_WIDTH-1:0] neg(input logic [N_WIDTH-1:0] a);
        return {~a[N_WIDTH-1], a[MW-1:0]};
    endfunction

    // Returns {overflow, sign, magnitude}.
    function automatic logic [N_WIDTH:0] sm_add(
        input logic [N_WIDTH-1:0] a,
        input logic [N_WIDTH-1:0] b
    );
        logic [MW:0]   s;
        logic [MW-1:0] m;
        logic          sg, ov;
        ov = 1'b0;
        if (a[N_WIDTH-1] == b[N_WIDTH-1]) begin
            s  = {1'b0, a[MW-1:0]} + {1'b0, b[MW-1:0]};
            m  = s[MW-1:0];
            sg = a[N_WIDTH-1];
            ov = s[MW] & SAT_EN;
            if (ov) m = '1;
        end else if (a[MW-1:0] >= b[MW-1:0]) begin
            m  = a[MW-1:0] - b[MW-1:0];
            sg = a[N_WIDTH-1];
        end else begin
            m  = b[MW-1:0] - a[MW-1:0];
            sg = b[N_WIDTH-1];
        end
        if (m == '0) sg = 1'b0;
        return {ov, sg, m};
    endfunction

    // Returns {overflow, sign, magnitude}; magnitude truncated toward zero.
    function automatic logic [N_WIDTH:0] sm_mul(
        input logic [N_WIDTH-1:0] a,
        input logic [N_WIDTH-1:0] b
    );
        logic [2*MW-1:0] p;
        logic [MW-1:0]   m;
        logic            sg, ov;
        p  = {{MW{1'b0}}, a[MW-1:0]} * {{MW{1'b0}}, b[MW-1:0]};
        m  = MW'(p >> Q_WIDTH);
        ov = (|(p >> (MW + Q_WIDTH))) & SAT_EN;
        if (ov) m = '1;
        sg = a[N_WIDTH-1] ^ b[N_WIDTH-1];
        if (m == '0) sg = 1'b0;
        return {ov, sg, m};
    endfunction

    // The single multiplier: k1*wz in MUL_K, sum[idx]*(1/r) otherwise.
    always_comb begin
        mul_a = sum_q[idx_q];
        mul_b = INV_R_COEF;
        if (state_q == S_MUL_K) begin
            mul_a = wz_q;
            mul_b = K1_COEF;
        end
    end

    assign mul_r = sm_mul(mul_a, mul_b);

    always_comb begin
        t_mv = sm_add(vx_q, neg(vy_q));
        t_pv = sm_add(vx_q, vy_q);
        s1   = sm_add(t_mv[N_WIDTH-1:0], neg(kw_q));
        s2   = sm_add(t_pv[N_WIDTH-1:0], kw_q);
        s3   = sm_add(t_pv[N_WIDTH-1:0], neg(kw_q));
        s4   = sm_add(t_mv[N_WIDTH-1:0], kw_q);
    end

    always_ff @(posedge KINEMATICS_SOLVER_CLOCK_50 or
                negedge KINEMATICS_SOLVER_RESET_InLow) begin
        if (!KINEMATICS_SOLVER_RESET_InLow) state_q <= S_IDLE;
        else                                state_q <= state_d;
    end

    always_comb begin
        state_d                        = state_q;
        KINEMATICS_SOLVER_BUSY_OutHigh = 1'b1;
        KINEMATICS_SOLVER_DONE_OutHigh = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                KINEMATICS_SOLVER_BUSY_OutHigh = 1'b0;
                if (KINEMATICS_SOLVER_START_InHigh) state_d = S_MUL_K;
            end
            S_MUL_K: state_d = S_SUM;
            S_SUM:   state_d = S_MUL_W;
            S_MUL_W: if (idx_q == 2'd3) state_d = S_DONE;
            S_DONE: begin
                KINEMATICS_SOLVER_DONE_OutHigh = 1'b1;
                state_d                        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge KINEMATICS_SOLVER_CLOCK_50 or
                negedge KINEMATICS_SOLVER_RESET_InLow) begin
        if (!KINEMATICS_SOLVER_RESET_InLow) begin
            idx_q   <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            wz_q    <= '0;
            kw_q    <= '0;
            kw_ov_q <= 1'b0;
            sov_q   <= '0;
            rov_q   <= '0;
            for (int i = 0; i < 4; i++) sum_q[i] <= '0;
            for (int i = 0; i < 3; i++) res_q[i] <= '0;
            KINEMATICS_SOLVER_W1_OutBus       <= '0;
            KINEMATICS_SOLVER_W2_OutBus       <= '0;
            KINEMATICS_SOLVER_W3_OutBus       <= '0;
            KINEMATICS_SOLVER_W4_OutBus       <= '0;
            KINEMATICS_SOLVER_OVERFLOW_OutBus <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (KINEMATICS_SOLVER_START_InHigh) begin
                    vx_q    <= KINEMATICS_SOLVER_TARGETVX_InBus;
                    vy_q    <= KINEMATICS_SOLVER_TARGETVY_InBus;
                    wz_q    <= KINEMATICS_SOLVER_TARGETWZ_InBus;
                    kw_ov_q <= 1'b0;
                    sov_q   <= '0;
                    rov_q   <= '0;
                end
                S_MUL_K: begin
                    kw_q    <= mul_r[N_WIDTH-1:0];
                    kw_ov_q <= mul_r[N_WIDTH];
                end
                S_SUM: begin
                    sum_q[0] <= s1[N_WIDTH-1:0];
                    sum_q[1] <= s2[N_WIDTH-1:0];
                    sum_q[2] <= s3[N_WIDTH-1:0];
                    sum_q[3] <= s4[N_WIDTH-1:0];
                    sov_q[0] <= s1[N_WIDTH] | t_mv[N_WIDTH] | kw_ov_q;
                    sov_q[1] <= s2[N_WIDTH] | t_pv[N_WIDTH] | kw_ov_q;
                    sov_q[2] <= s3[N_WIDTH] | t_pv[N_WIDTH] | kw_ov_q;
                    sov_q[3] <= s4[N_WIDTH] | t_mv[N_WIDTH] | kw_ov_q;
                    idx_q    <= '0;
                end
                S_MUL_W: begin
                    // After three shifts res_q/rov_q hold wheels 1..3 in order.
                    res_q[0] <= res_q[1];
                    res_q[1] <= res_q[2];
                    res_q[2] <= mul_r[N_WIDTH-1:0];
                    rov_q    <= {sov_q[idx_q] | mul_r[N_WIDTH], rov_q[2:1]};
                    idx_q    <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        KINEMATICS_SOLVER_W1_OutBus <= res_q[0];
                        KINEMATICS_SOLVER_W2_OutBus <= res_q[1];
                        KINEMATICS_SOLVER_W3_OutBus <= res_q[2];
                        KINEMATICS_SOLVER_W4_OutBus <= mul_r[N_WIDTH-1:0];
                        KINEMATICS_SOLVER_OVERFLOW_OutBus <=
                            {sov_q[3] | mul_r[N_WIDTH], rov_q};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kinematics_solver.sv
// tb_kinematics_solver: directed vectors with hand-computed wheel speeds.
// Covers reset, latency, sign handling, back-to-back starts, mid-run reset.
module tb_kinematics_solver;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] vx = '0, vy = '0, wz = '0;
    logic [31:0] w1, w2, w3, w4;
    logic        busy, done;
    logic [3:0]  ovf;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat;
    int          dcnt;
    int          seen;

    always #5 clk = ~clk;

    kinematics_solver dut (
        .KINEMATICS_SOLVER_CLOCK_50       (clk),
        .KINEMATICS_SOLVER_RESET_InLow    (rst_n),
        .KINEMATICS_SOLVER_START_InHigh   (start),
        .KINEMATICS_SOLVER_TARGETVX_InBus (vx),
        .KINEMATICS_SOLVER_TARGETVY_InBus (vy),
        .KINEMATICS_SOLVER_TARGETWZ_InBus (wz),
        .KINEMATICS_SOLVER_W1_OutBus      (w1),
        .KINEMATICS_SOLVER_W2_OutBus      (w2),
        .KINEMATICS_SOLVER_W3_OutBus      (w3),
        .KINEMATICS_SOLVER_W4_OutBus      (w4),
        .KINEMATICS_SOLVER_BUSY_OutHigh   (busy),
        .KINEMATICS_SOLVER_DONE_OutHigh   (done),
        .KINEMATICS_SOLVER_OVERFLOW_OutBus(ovf)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept on the next rising edge, then scramble the inputs.
    task automatic launch(input logic [31:0] a, b, c);
        @(negedge clk);
        vx = a; vy = b; wz = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vx = 32'h5A5A5A5A; vy = 32'hA5A5A5A5; wz = 32'h3C3C3C3C;
    endtask

    task automatic wait_done(output int l);
        l = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic run_case(input string tag, input logic [31:0] a, b, c,
                            input logic [31:0] e1, e2, e3, e4,
                            input logic [3:0] eo);
        int l;
        launch(a, b, c);
        check({tag, ".busy"}, {31'b0, busy}, 32'd1);
        wait_done(l);
        check({tag, ".lat"}, 32'(l), 32'd6);
        check({tag, ".w1"}, w1, e1);
        check({tag, ".w2"}, w2, e2);
        check({tag, ".w3"}, w3, e3);
        check({tag, ".w4"}, w4, e4);
        check({tag, ".ovf"}, {28'b0, ovf}, {28'b0, eo});
        @(posedge clk); #1;
        check({tag, ".done_off"}, {31'b0, done}, 32'd0);
        check({tag, ".idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        #12;
        check("rst.w1", w1, 32'h0);
        check("rst.w4", w4, 32'h0);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.done", {31'b0, done}, 32'd0);
        check("rst.ovf", {28'b0, ovf}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        run_case("vx1", 32'h00008000, 32'h0, 32'h0,
                 32'h000DCB09, 32'h000DCB09, 32'h000DCB09, 32'h000DCB09, 4'h0);
        run_case("vy1", 32'h0, 32'h00008000, 32'h0,
                 32'h800DCB09, 32'h000DCB09, 32'h000DCB09, 32'h800DCB09, 4'h0);
        run_case("wz1", 32'h0, 32'h0, 32'h00008000,
                 32'h8002468B, 32'h0002468B, 32'h8002468B, 32'h0002468B, 4'h0);
        run_case("mix", 32'h00008000, 32'h00004000, 32'h0,
                 32'h0006E584, 32'h0014B08D, 32'h0014B08D, 32'h0006E584, 4'h0);
        run_case("zero", 32'h00008000, 32'h00008000, 32'h0,
                 32'h00000000, 32'h001B9612, 32'h001B9612, 32'h00000000, 4'h0);
        run_case("negz", 32'h80000000, 32'h0, 32'h0,
                 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 4'h0);

        launch(32'h7FFFFFFF, 32'h80008000, 32'h0);
        wait_done(lat);
        check("big.lat", 32'(lat), 32'd6);
`ifdef KINEMATICS_SOLVER_SATURATION_EN
        check("big.w1", w1, 32'h7FFFFFFF);
        check("big.ovf0", {31'b0, ovf[0]}, 32'd1);
`else
        check("big.w1", w1, 32'h000DCAED);
        check("big.ovf", {28'b0, ovf}, 32'd0);
`endif
        @(posedge clk); #1;

        // START held high: accepts at edges 0 and 8, DONE after 6 and 14.
        dcnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            vx = 32'((c + 1) * 8192); vy = '0; wz = '0; start = 1'b1;
            @(posedge clk); #1;
            if (done) begin
                dcnt++;
                if (dcnt == 1) begin
                    check("cont.at1", 32'(c), 32'd6);
                    check("cont.w1a", w1, 32'h000372C2);
                    check("cont.w4a", w4, 32'h000372C2);
                end else begin
                    check("cont.at2", 32'(c), 32'd14);
                    check("cont.w1b", w1, 32'h001F08D4);
                    check("cont.w3b", w3, 32'h001F08D4);
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("cont.count", 32'(dcnt), 32'd2);
        @(posedge clk); #1;
        check("cont.idle", {31'b0, busy}, 32'd0);

        // Reset while in SUM.
        launch(32'h00008000, 32'h00004000, 32'h00008000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid.w1", w1, 32'h0);
        check("mid.w3", w3, 32'h0);
        check("mid.busy", {31'b0, busy}, 32'd0);
        check("mid.ovf", {28'b0, ovf}, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("mid.nodone", 32'(seen), 32'd0);
        check("mid.w2", w2, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_case("post", 32'h00008000, 32'h0, 32'h0,
                 32'h000DCB09, 32'h000DCB09, 32'h000DCB09, 32'h000DCB09, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
